// File: rtl/spi_word_slave_pkg.sv
// Shared types and constants for the SPI word slave.
// No logic, no latency.
// No flow control involved.
`include "spi_defs.vh"

package spi_word_slave_pkg;

    localparam logic [1:0] MODE0 = `SPI_MODE0;
    localparam logic [1:0] MODE1 = `SPI_MODE1;
    localparam logic [1:0] MODE2 = `SPI_MODE2;
    localparam logic [1:0] MODE3 = `SPI_MODE3;

    typedef enum logic {
        ST_IDLE  = `SPI_ST_IDLE,
        ST_SHIFT = `SPI_ST_SHIFT
    } state_e;

    // SCLK and SS get one extra stage so edges are taken off settled flops.
    localparam int SYNC_DEPTH_CTRL = 3;
    localparam int SYNC_DEPTH_DATA = 2;

    // Word counter that sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_defs.vh
// SPI mode constants ({CPOL,CPHA}) and slave FSM state encodings.
// Pure definitions, no logic; guarded so several files may include it.
// No flow control involved.
`ifndef SPI_DEFS_VH
`define SPI_DEFS_VH

`define SPI_MODE0 2'b00
`define SPI_MODE1 2'b01
`define SPI_MODE2 2'b10
`define SPI_MODE3 2'b11

`define SPI_ST_IDLE  1'b0
`define SPI_ST_SHIFT 1'b1

`endif

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous control line with edge pulses.
// Edges appear DEPTH-1 sysClk cycles after the input changes.
// No flow control; edges are single-cycle pulses and are never held.
module spi_sync_edge
    import spi_word_slave_pkg::*;
#(
    parameter int   DEPTH   = SYNC_DEPTH_CTRL,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [DEPTH-1:0] sync_q;

    // Shift the raw input through the chain; index 0 is the metastable stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    // Edges are judged on the two oldest stages only.
    assign rise_o =  sync_q[DEPTH-2] & ~sync_q[DEPTH-1];
    assign fall_o = ~sync_q[DEPTH-2] &  sync_q[DEPTH-1];

endmodule

// File: rtl/spi_word_slave.sv
// SPI slave that frames the serial stream into WIDTH-bit words in the sysClk domain.
// Latency: rxValid/rxData appear ~3 sysClk cycles after the last sample SCLK edge.
// No backpressure: rxValid/txLoad are pulses; the host must keep up between words.
module spi_word_slave
    import spi_word_slave_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CPOL      = 1,
    parameter int CPHA      = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             sysClk,
    input  logic             usrReset,
    input  logic             SCLK,
    input  logic             MOSI,
    input  logic             SS,
    output logic             MISO,
    output logic [WIDTH-1:0] rxData,
    output logic             rxValid,
    input  logic [WIDTH-1:0] txData,
    output logic             txLoad,
    output logic             frameErr,
    output logic [7:0]       wordCnt
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [1:0]       SPI_MODE = {CPOL[0], CPHA[0]};
    // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling one.
    localparam logic SAMP_ON_RISE = (SPI_MODE == MODE0) || (SPI_MODE == MODE3);
    localparam logic SAMP_ON_FALL = (SPI_MODE == MODE1) || (SPI_MODE == MODE2);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic samp_edge, shft_edge, armed, mosi_s, tx_bit;

    logic [SYNC_DEPTH_DATA-1:0] mosi_q;
    logic [SYNC_DEPTH_CTRL-1:0] live_q;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0]       word_cnt_q,  word_cnt_d;
    logic [WIDTH-1:0] rx_sh_q,     rx_sh_d;
    logic [WIDTH-1:0] tx_sh_q,     tx_sh_d;
    logic [WIDTH-1:0] rx_data_q,   rx_data_d;
    logic             rx_vld_q,    rx_vld_d;
    logic             tx_load_q,   tx_load_d;
    logic             frame_err_q, frame_err_d;
    logic             first_q,     first_d;
    logic             wrap_q,      wrap_d;

    spi_sync_edge #(.DEPTH(SYNC_DEPTH_CTRL), .RST_VAL(CPOL[0])) u_sclk_sync (
        .clk_i  (sysClk),
        .rst_i  (usrReset),
        .d_i    (SCLK),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.DEPTH(SYNC_DEPTH_CTRL), .RST_VAL(1'b1)) u_ss_sync (
        .clk_i  (sysClk),
        .rst_i  (usrReset),
        .d_i    (SS),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    assign samp_edge = (SAMP_ON_RISE & sclk_rise) | (SAMP_ON_FALL & sclk_fall);
    assign shft_edge = (SAMP_ON_RISE & sclk_fall) | (SAMP_ON_FALL & sclk_rise);
    assign mosi_s    = mosi_q[SYNC_DEPTH_DATA-1];
    // The SS chain holds reset values for a few cycles; a "fall" seen before
    // real samples reach the edge detector is a reset artifact, not a frame start.
    assign armed     = live_q[SYNC_DEPTH_CTRL-1];
    assign tx_bit    = (MSB_FIRST != 0) ? tx_sh_q[WIDTH-1] : tx_sh_q[0];
    assign MISO      = (state_q == ST_SHIFT) ? tx_bit : 1'bz;

    assign rxData   = rx_data_q;
    assign rxValid  = rx_vld_q;
    assign txLoad   = tx_load_q;
    assign frameErr = frame_err_q;
    assign wordCnt  = word_cnt_q;

    // Next-state logic: frame start/stop on SS edges, bit/word handling on SCLK edges.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        rx_data_d   = rx_data_q;
        rx_vld_d    = 1'b0;
        tx_load_d   = 1'b0;
        frame_err_d = 1'b0;
        first_d     = first_q;
        wrap_d      = wrap_q;
        case (state_q)
            ST_IDLE: begin
                // SCLK edges coinciding with the SS fall are deliberately dropped.
                if (ss_fall && armed) begin
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = '0;
                    word_cnt_d = 8'd0;
                    tx_sh_d    = txData;
                    tx_load_d  = 1'b1;
                    first_d    = (CPHA != 0);
                    wrap_d     = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (samp_edge) begin
                    if (MSB_FIRST != 0) begin
                        rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_s};
                    end else begin
                        rx_sh_d = {mosi_s, rx_sh_q[WIDTH-1:1]};
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_sh_d;
                        rx_vld_d   = 1'b1;
                        bit_cnt_d  = '0;
                        word_cnt_d = sat_inc8(word_cnt_q);
                        wrap_d     = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shft_edge) begin
                    if (wrap_q) begin
                        // Word boundary: next word goes out starting at its first bit.
                        tx_sh_d   = txData;
                        tx_load_d = 1'b1;
                        wrap_d    = 1'b0;
                    end else if (first_q) begin
                        // First bit was preloaded at SS fall; hold it for this edge.
                        first_d = 1'b0;
                    end else if (MSB_FIRST != 0) begin
                        tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                    end else begin
                        tx_sh_d = {1'b0, tx_sh_q[WIDTH-1:1]};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers, MOSI synchroniser and the post-reset arming delay.
    always_ff @(posedge sysClk or posedge usrReset) begin
        if (usrReset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            word_cnt_q  <= 8'd0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_vld_q    <= 1'b0;
            tx_load_q   <= 1'b0;
            frame_err_q <= 1'b0;
            first_q     <= 1'b0;
            wrap_q      <= 1'b0;
            mosi_q      <= '0;
            live_q      <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_vld_q    <= rx_vld_d;
            tx_load_q   <= tx_load_d;
            frame_err_q <= frame_err_d;
            first_q     <= first_d;
            wrap_q      <= wrap_d;
            mosi_q      <= {mosi_q[SYNC_DEPTH_DATA-2:0], MOSI};
            live_q      <= {live_q[SYNC_DEPTH_CTRL-2:0], 1'b1};
        end
    end

endmodule

// File: tb/tb_spi_word_slave.sv
// Bench: three slaves (mode 3/W8/MSB, mode 0/W16/MSB, mode 1/W8/LSB) on one SPI master.
// Only the selected slave sees SS low; the others must stay silent.
// Expected data come from the planned words and the SPI framing rules.
module tb_spi_word_slave;

    localparam int HALF = 80;   // SCLK half period, 16x slower than sysClk

    logic        sysClk = 1'b0;
    logic        usrReset;
    logic        sck_ph;        // 0 = idle phase, 1 = after leading edge
    logic        mosi;
    logic [2:0]  ss;
    logic [7:0]  tx0, tx2;
    logic [15:0] tx1;
    logic [7:0]  rx0, rx2;
    logic [15:0] rx1;
    logic [2:0]  rxv, txl, fe;
    logic [7:0]  wc0, wc1, wc2;
    wire         miso0, miso1, miso2;
    wire         sclk0 = ~sck_ph;
    wire         sclk1 = sck_ph;
    wire         sclk2 = sck_ph;
    wire  [2:0]  miso_z = {miso2 === 1'bz, miso1 === 1'bz, miso0 === 1'bz};
    wire  [2:0]  miso_v = {miso2, miso1, miso0};

    always #5 sysClk = ~sysClk;

    spi_word_slave #(.WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) u0 (
        .sysClk(sysClk), .usrReset(usrReset), .SCLK(sclk0), .MOSI(mosi), .SS(ss[0]),
        .MISO(miso0), .rxData(rx0), .rxValid(rxv[0]), .txData(tx0), .txLoad(txl[0]),
        .frameErr(fe[0]), .wordCnt(wc0));
    spi_word_slave #(.WIDTH(16), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u1 (
        .sysClk(sysClk), .usrReset(usrReset), .SCLK(sclk1), .MOSI(mosi), .SS(ss[1]),
        .MISO(miso1), .rxData(rx1), .rxValid(rxv[1]), .txData(tx1), .txLoad(txl[1]),
        .frameErr(fe[1]), .wordCnt(wc1));
    spi_word_slave #(.WIDTH(8), .CPOL(0), .CPHA(1), .MSB_FIRST(0)) u2 (
        .sysClk(sysClk), .usrReset(usrReset), .SCLK(sclk2), .MOSI(mosi), .SS(ss[2]),
        .MISO(miso2), .rxData(rx2), .rxValid(rxv[2]), .txData(tx2), .txLoad(txl[2]),
        .frameErr(fe[2]), .wordCnt(wc2));

    int n_tests = 0;
    int n_fail  = 0;

    int          sel = -1;
    int          ld_frame, ld_at_rx;
    int          rxv_cnt[3], txl_cnt[3], fe_cnt[3];
    int          rxv_base[3], txl_base[3], fe_base[3];
    logic [15:0] rx_plan[8], tx_plan[8], got_tx[8], last_rx[3];
    logic [15:0] rx_got[$];

    function automatic int wid(int s);
        return (s == 1) ? 16 : 8;
    endfunction
    function automatic bit cpha(int s);
        return s != 1;
    endfunction
    function automatic bit msbf(int s);
        return s != 2;
    endfunction
    function automatic logic [15:0] wmask(int s);
        return (s == 1) ? 16'hFFFF : 16'h00FF;
    endfunction
    function automatic logic [15:0] rxd(int s);
        case (s)
            0:       return {8'h00, rx0};
            1:       return rx1;
            default: return {8'h00, rx2};
        endcase
    endfunction
    function automatic logic [7:0] wcv(int s);
        case (s)
            0:       return wc0;
            1:       return wc1;
            default: return wc2;
        endcase
    endfunction

    task automatic set_tx(input int s, input logic [15:0] v);
        case (s)
            0:       tx0 = v[7:0];
            1:       tx1 = v;
            default: tx2 = v[7:0];
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Host side: count pulses, capture received words, present the next tx word.
    always @(negedge sysClk) begin
        for (int i = 0; i < 3; i++) begin
            if (rxv[i]) begin
                rxv_cnt[i]++;
                if (i == sel) begin
                    rx_got.push_back(rxd(i));
                    ld_at_rx = ld_frame;
                end
            end
            if (txl[i]) begin
                txl_cnt[i]++;
                if (i == sel) begin
                    ld_frame++;
                    set_tx(i, tx_plan[ld_frame % 8]);
                end
            end
            if (fe[i]) fe_cnt[i]++;
        end
    end

    task automatic snap();
        for (int i = 0; i < 3; i++) begin
            rxv_base[i] = rxv_cnt[i];
            txl_base[i] = txl_cnt[i];
            fe_base[i]  = fe_cnt[i];
        end
    endtask

    task automatic start_frame(input int s);
        sel      = s;
        ld_frame = 0;
        ld_at_rx = -1;
        rx_got.delete();
        set_tx(s, tx_plan[0]);
        snap();
        #(HALF / 2);
        ss[s] = 1'b0;
        #(HALF);
    endtask

    // Master clocks n bits starting at global bit index b0 of the planned words.
    task automatic clock_bits(input int s, input int n, input int b0);
        int w, k, pos;
        w = wid(s);
        for (int b = b0; b < b0 + n; b++) begin
            k   = b / w;
            pos = msbf(s) ? (w - 1 - (b % w)) : (b % w);
            if (!cpha(s)) begin
                mosi = rx_plan[k][pos];
                #(HALF);
                got_tx[k][pos] = miso_v[s];
                sck_ph = 1'b1;
                #(HALF);
                sck_ph = 1'b0;
            end else begin
                sck_ph = 1'b1;
                mosi   = rx_plan[k][pos];
                #(HALF);
                got_tx[k][pos] = miso_v[s];
                sck_ph = 1'b0;
                #(HALF);
            end
        end
    endtask

    task automatic end_frame(input int s);
        #(HALF);
        ss[s] = 1'b1;
        #200;
        sel = -1;
    endtask

    task automatic others_quiet(input int s);
        for (int i = 0; i < 3; i++) begin
            if (i != s) begin
                chk("idle_rxvalid", rxv_cnt[i] - rxv_base[i], 0);
                chk("idle_txload",  txl_cnt[i] - txl_base[i], 0);
                chk("idle_miso_z",  {31'd0, miso_z[i]}, 1);
            end
        end
    endtask

    task automatic check_frame(input int s, input int nw);
        chk("rx_count", rxv_cnt[s] - rxv_base[s], nw);
        for (int k = 0; k < nw; k++) begin
            if (k < rx_got.size()) chk("rx_word", rx_got[k], rx_plan[k]);
            chk("miso_word", got_tx[k] & wmask(s), tx_plan[k]);
        end
        chk("word_cnt", wcv(s), (nw > 255) ? 255 : nw);
        chk("loads_in_words", ld_at_rx, nw);
        // Mode with CPHA=0 reloads on the trailing edge after the final word too.
        chk("loads_total", txl_cnt[s] - txl_base[s], nw + (cpha(s) ? 0 : 1));
        chk("frame_err", fe_cnt[s] - fe_base[s], 0);
        chk("miso_z_end", {31'd0, miso_z[s]}, 1);
        others_quiet(s);
        last_rx[s] = rx_plan[nw - 1];
    endtask

    task automatic run_frame(input int s, input int nw);
        start_frame(s);
        clock_bits(s, nw * wid(s), 0);
        end_frame(s);
        check_frame(s, nw);
    endtask

    task automatic rand_plan(input int s);
        for (int k = 0; k < 8; k++) begin
            rx_plan[k] = 16'($urandom) & wmask(s);
            tx_plan[k] = 16'($urandom) & wmask(s);
        end
    endtask

    initial begin
        usrReset = 1'b1;
        ss       = 3'b111;
        sck_ph   = 1'b0;
        mosi     = 1'b0;
        tx0 = '0; tx1 = '0; tx2 = '0;
        for (int i = 0; i < 3; i++) begin
            rxv_cnt[i] = 0; txl_cnt[i] = 0; fe_cnt[i] = 0; last_rx[i] = '0;
        end
        #33;
        for (int i = 0; i < 3; i++) begin
            chk("rst_rxdata", rxd(i), 0);
            chk("rst_wordcnt", wcv(i), 0);
            chk("rst_miso_z", {31'd0, miso_z[i]}, 1);
        end
        chk("rst_pulses", {rxv, txl, fe}, 0);
        @(negedge sysClk);
        usrReset = 1'b0;
        #100;

        // Mode 3, 8-bit MSB first: 0xA5 in, 0x3C out.
        rand_plan(0);
        rx_plan[0] = 16'h00A5;
        tx_plan[0] = 16'h003C;
        run_frame(0, 1);

        // Mode 0, 16-bit, three words back to back.
        rand_plan(1);
        rx_plan[0] = 16'h1234;
        rx_plan[1] = 16'hBEEF;
        rx_plan[2] = 16'h0001;
        run_frame(1, 3);

        // Mode 1, LSB first: 0x01 arrives as a leading 1 bit.
        rand_plan(2);
        rx_plan[0] = 16'h0001;
        run_frame(2, 1);

        // Random frames on random slaves.
        for (int r = 0; r < 6; r++) begin
            int s, nw;
            s  = $urandom_range(0, 2);
            nw = $urandom_range(1, 4);
            rand_plan(s);
            run_frame(s, nw);
        end

        // SS released after 5 of 8 bits.
        rand_plan(0);
        start_frame(0);
        clock_bits(0, 5, 0);
        end_frame(0);
        chk("abort_frameerr", fe_cnt[0] - fe_base[0], 1);
        chk("abort_rxvalid", rxv_cnt[0] - rxv_base[0], 0);
        chk("abort_rxdata", rxd(0), last_rx[0]);
        chk("abort_miso_z", {31'd0, miso_z[0]}, 1);

        // Reset mid-frame with SS held low, then a fresh frame.
        rand_plan(0);
        start_frame(0);
        clock_bits(0, 3, 0);
        usrReset = 1'b1;
        #20;
        usrReset = 1'b0;
        #1;
        chk("mid_rst_rxdata", rxd(0), 0);
        chk("mid_rst_wordcnt", wcv(0), 0);
        chk("mid_rst_miso_z", {31'd0, miso_z[0]}, 1);
        chk("mid_rst_pulses", {rxv[0], txl[0], fe[0]}, 0);
        snap();
        #(HALF);
        clock_bits(0, 8, 0);
        chk("post_rst_rxvalid", rxv_cnt[0] - rxv_base[0], 0);
        chk("post_rst_txload", txl_cnt[0] - txl_base[0], 0);
        chk("post_rst_frameerr", fe_cnt[0] - fe_base[0], 0);
        chk("post_rst_miso_z", {31'd0, miso_z[0]}, 1);
        ss[0] = 1'b1;
        sel   = -1;
        #200;
        rand_plan(0);
        rx_plan[0] = 16'h005A;
        run_frame(0, 1);

        // SCLK activity with every SS high.
        snap();
        for (int t = 0; t < 16; t++) begin
            mosi   = 1'($urandom);
            sck_ph = ~sck_ph;
            #(HALF);
        end
        #100;
        for (int i = 0; i < 3; i++) begin
            chk("ss_high_rxvalid", rxv_cnt[i] - rxv_base[i], 0);
            chk("ss_high_txload", txl_cnt[i] - txl_base[i], 0);
            chk("ss_high_frameerr", fe_cnt[i] - fe_base[i], 0);
            chk("ss_high_miso_z", {31'd0, miso_z[i]}, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
